// File: rtl/m_bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL bit positions, MODE encodings and FSM state encoding.
package m_bus_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/m_bus_timer.sv
// Countdown timer responder on the M-stage bus: CTRL/PRESET/COUNT registers,
// a four-state count FSM and a combinational read mux; IRQ feeds CP0 HWInt.
module m_bus_timer
    import m_bus_timer_pkg::*;
#(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = {CNT_W{1'b0}}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             flag_q, flag_d;

    logic [1:0]       reg_sel_s;
    logic             en_s;
    logic             auto_s;
    logic             irq_set_s;
    logic             flag_clr_s;
    logic             unused_addr_s;

    assign reg_sel_s     = Addr[3:2];
    assign en_s          = ctrl_q[CTRL_EN];
    // MODE 1x behaves as one-shot, so only the exact auto-reload code counts
    assign auto_s        = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
    assign unused_addr_s = ^{Addr[31:4], Addr[1:0]};

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= 4'h0;
            preset_q <= PRESET_RST;
            count_q  <= {CNT_W{1'b0}};
            state_q  <= ST_IDLE;
            flag_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            flag_q   <= flag_d;
        end
    end

    // FSM next state plus bus writes; FSM decisions use pre-write CTRL
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        flag_d     = flag_q;
        irq_set_s  = 1'b0;
        flag_clr_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d    = preset_q;
                flag_clr_s = 1'b1;
                state_d    = ST_CNT;
            end
            ST_CNT: begin
                if (!en_s) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // Terminal count: clamp at zero, never wrap
                    count_d   = {CNT_W{1'b0}};
                    irq_set_s = 1'b1;
                    state_d   = ST_INT;
                    if (!auto_s) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end else begin
                        ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN];
                    end
                end
            end
            ST_INT: begin
                // Clearing on the way to LOAD keeps the auto-reload IRQ a one-cycle pulse
                if (auto_s) begin
                    flag_clr_s = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (WE) begin
            case (reg_sel_s)
                REG_CTRL: begin
                    ctrl_d     = Din[3:0];
                    flag_clr_s = 1'b1;
                end
                REG_PRESET: begin
                    preset_d = Din[CNT_W-1:0];
                end
                default: begin
                    preset_d = preset_q;
                end
            endcase
        end else begin
            preset_d = preset_d;
        end

        // A same-edge set beats any clear so a terminal event is never lost
        if (irq_set_s) begin
            flag_d = 1'b1;
        end else if (flag_clr_s) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Read mux follows Addr in the same cycle
    always_comb begin
        Dout = 32'h0000_0000;
        case (reg_sel_s)
            REG_CTRL:   Dout = {28'h000_0000, ctrl_q};
            REG_PRESET: Dout = 32'(preset_q);
            REG_COUNT:  Dout = 32'(count_q);
            REG_NONE:   Dout = 32'h0000_0000;
            default:    Dout = 32'h0000_0000;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & flag_q;

endmodule
